// File: rtl/parallel_adder.sv
// parallel_adder: registered unsigned adder computed by dataflow, behavioral and structural paths with cross-check
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic w_xy, w_xc, w_yc;
  xor g_s (s, x, y, cin);
  and g_xy (w_xy, x, y);
  and g_xc (w_xc, x, cin);
  and g_yc (w_yc, y, cin);
  or  g_c (cout, w_xy, w_xc, w_yc);
endmodule

module parallel_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH:0]   sum_dataflow,
  output logic [WIDTH:0]   sum_behavioral,
  output logic [WIDTH:0]   sum_structural,
  output logic             out_valid,
  output logic             mismatch,
  output logic             err_sticky
);
  logic [WIDTH:0] w_sum_df, w_sum_beh, w_sum_str, w_carry;
  logic           w_c, w_diff;
  assign w_sum_df = {1'b0, a} + {1'b0, b};
  always_comb begin
    w_c = 1'b0;
    w_sum_beh = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_sum_beh[k] = a[k] ^ b[k] ^ w_c;
      w_c = (a[k] & b[k]) | (a[k] & w_c) | (b[k] & w_c);
    end
    w_sum_beh[WIDTH] = w_c;
  end
  assign w_carry[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .x   (a[i]),
      .y   (b[i]),
      .cin (w_carry[i]),
      .s   (w_sum_str[i]),
      .cout(w_carry[i+1])
    );
  end
  assign w_sum_str[WIDTH] = w_carry[WIDTH];
  assign w_diff = (w_sum_df != w_sum_beh) | (w_sum_df != w_sum_str) | (w_sum_beh != w_sum_str);
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_dataflow   <= '0;
      sum_behavioral <= '0;
      sum_structural <= '0;
      out_valid      <= 1'b0;
      mismatch       <= 1'b0;
      err_sticky     <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      mismatch   <= in_valid & w_diff;
      err_sticky <= err_sticky | (in_valid & w_diff);
      if (in_valid) begin
        sum_dataflow   <= w_sum_df;
        sum_behavioral <= w_sum_beh;
        sum_structural <= w_sum_str;
      end
    end
  end
endmodule

// File: tb/tb_parallel_adder.sv
// tb_parallel_adder: directed and exhaustive self-checking bench for parallel_adder at WIDTH=4
module tb_parallel_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       in_valid = 1'b0;
  logic [4:0] sum_dataflow, sum_behavioral, sum_structural;
  logic       out_valid, mismatch, err_sticky;
  int         pass = 0;
  int         total = 0;
  parallel_adder #(.WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .a             (a),
    .b             (b),
    .in_valid      (in_valid),
    .sum_dataflow  (sum_dataflow),
    .sum_behavioral(sum_behavioral),
    .sum_structural(sum_structural),
    .out_valid     (out_valid),
    .mismatch      (mismatch),
    .err_sticky    (err_sticky)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic r, input logic v, input logic [3:0] x, input logic [3:0] y);
    rst = r;
    in_valid = v;
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    cyc(1'b1, 1'b1, 4'd9, 4'd9);
    cyc(1'b1, 1'b1, 4'd9, 4'd9);
    total++;
    if ({sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch, err_sticky} !== 18'd0)
      $display("FAIL reset: got %h/%h/%h v=%b m=%b e=%b, want all 0", sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch, err_sticky);
    else pass++;
    cyc(1'b0, 1'b1, 4'd2, 4'd3);
    total++;
    if ({sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch} !== {5'd5, 5'd5, 5'd5, 2'b10})
      $display("FAIL first_after_reset: got %0d/%0d/%0d v=%b m=%b, want 5/5/5 v=1 m=0", sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch);
    else pass++;
  endtask
  task automatic test_add;
    logic [3:0] va [5] = '{4'd3, 4'd7, 4'd8, 4'd15, 4'd0};
    logic [3:0] vb [5] = '{4'd5, 4'd9, 4'd1, 4'd15, 4'd0};
    logic [4:0] ve [5] = '{5'd8, 5'd16, 5'd9, 5'd30, 5'd0};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, va[i], vb[i]);
      total++;
      if ({sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch} !== {ve[i], ve[i], ve[i], 2'b10})
        $display("FAIL add_%0d+%0d: got %0d/%0d/%0d v=%b m=%b, want %0d v=1 m=0", va[i], vb[i], sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch, ve[i]);
      else pass++;
    end
  endtask
  task automatic test_hold;
    cyc(1'b0, 1'b1, 4'd3, 4'd5);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 4'd15, 4'd14);
      total++;
      if ({sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch} !== {5'd8, 5'd8, 5'd8, 2'b00})
        $display("FAIL hold_%0d: got %0d/%0d/%0d v=%b m=%b, want 8 v=0 m=0", i, sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch);
      else pass++;
    end
  endtask
  task automatic test_reset_midstream;
    cyc(1'b0, 1'b1, 4'd6, 4'd7);
    cyc(1'b1, 1'b1, 4'd15, 4'd15);
    total++;
    if ({sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch, err_sticky} !== 18'd0)
      $display("FAIL mid_reset: got %0d/%0d/%0d v=%b m=%b e=%b, want all 0", sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch, err_sticky);
    else pass++;
    cyc(1'b0, 1'b0, 4'd1, 4'd1);
    total++;
    if ({sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch} !== 17'd0)
      $display("FAIL discarded_operand: got %0d/%0d/%0d v=%b m=%b, want all 0", sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch);
    else pass++;
    cyc(1'b0, 1'b1, 4'd10, 4'd4);
    total++;
    if ({sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch} !== {5'd14, 5'd14, 5'd14, 2'b10})
      $display("FAIL resume: got %0d/%0d/%0d v=%b m=%b, want 14 v=1 m=0", sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch);
    else pass++;
  endtask
  task automatic test_back_to_back;
    logic [4:0] e;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        cyc(1'b0, 1'b1, 4'(x), 4'(y));
        e = 5'(x + y);
        total++;
        if ({sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch} !== {e, e, e, 2'b10})
          $display("FAIL sweep_%0d+%0d: got %0d/%0d/%0d v=%b m=%b, want %0d v=1 m=0", x, y, sum_dataflow, sum_behavioral, sum_structural, out_valid, mismatch, e);
        else pass++;
      end
    cyc(1'b0, 1'b0, 4'd0, 4'd0);
    total++;
    if ({out_valid, mismatch, err_sticky} !== 3'b000)
      $display("FAIL sweep_end: got v=%b m=%b e=%b, want 0/0/0", out_valid, mismatch, err_sticky);
    else pass++;
  endtask
  initial begin
    test_reset;
    test_add;
    test_hold;
    test_reset_midstream;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/parallel_adder.md
PARALLEL_ADDER -- requirements
Module: parallel_adder

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; the sum is WIDTH+1 bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a  input  WIDTH  unsigned operand A.
REQ-005 b  input  WIDTH  unsigned operand B.
REQ-006 in_valid  input  1  when high, a/b are sampled this clock edge.
REQ-007 sum_dataflow  output  WIDTH+1  registered result of the dataflow adder path.
REQ-008 sum_behavioral  output  WIDTH+1  registered result of the behavioral adder path.
REQ-009 sum_structural  output  WIDTH+1  registered result of the structural adder path.
REQ-010 out_valid  output  1  high for one cycle when the sum outputs carry a new result.
REQ-011 mismatch  output  1  high with out_valid when the three path results are not all equal.
REQ-012 err_sticky  output  1  latched mismatch indication, cleared only by rst.

Function
REQ-013 The dataflow path SHALL compute the sum as a single continuous-assignment expression: zero-extended a plus zero-extended b, WIDTH+1 bits.
REQ-014 The behavioral path SHALL compute the sum in a combinational procedural block that iterates bit 0..WIDTH-1 with an explicit carry variable, carry-in 0, and places the final carry in bit WIDTH.
REQ-015 The structural path SHALL be a ripple-carry chain of WIDTH instantiated full-adder cells, with carry-in 0; bit 0 uses a full adder, not a half adder.
REQ-016 The full-adder cell SHALL be a separate module, built from gate primitives: sum = x^y^cin, cout = (x&y)|(x&cin)|(y&cin).
REQ-017 All three paths SHALL be unsigned, without overflow loss: the result is always exactly a+b in WIDTH+1 bits, and the MSB is the carry-out.
REQ-018 On a clock edge with in_valid=1 and rst=0, all three sum outputs SHALL load their path results; out_valid SHALL be 1 on the next cycle (latency 1).
REQ-019 On a clock edge with in_valid=0 and rst=0, the sum outputs SHALL hold their values, and out_valid and mismatch SHALL be 0.
REQ-020 mismatch SHALL be registered together with the sums and SHALL be 1 only when out_valid=1 and any two path results differ.
REQ-021 err_sticky SHALL be set on the cycle mismatch is first 1, and SHALL remain 1 until rst.
REQ-022 Back-to-back in_valid SHALL be accepted every cycle, with no stall and no backpressure.
REQ-023 The design SHALL have no combinational path from inputs to outputs.

Reset
REQ-024 When rst=1 at a rising edge, all sum outputs, out_valid, mismatch and err_sticky SHALL become 0, regardless of in_valid.
REQ-025 rst SHALL take priority over in_valid on the same edge; an operand presented with rst high is discarded.
REQ-026 After rst deasserts, the first in_valid edge SHALL produce a normal result one cycle later.

Verification
REQ-027 a=3, b=5, in_valid=1 -> next cycle all three sums = 8, out_valid=1, mismatch=0.
REQ-028 a=7, b=9 -> all sums = 16 (carry-out bit 4 set); a=8, b=1 -> all sums = 9.
REQ-029 a=15, b=15 -> all sums = 30; a=0, b=0 -> all sums = 0; mismatch=0 throughout.
REQ-030 in_valid pulses, then held low for 3 cycles -> sums hold the last value, out_valid=0.
REQ-031 rst asserted mid-stream with in_valid=1 -> next cycle all outputs 0; the operand on the reset edge produces no result.
REQ-032 Exhaustive sweep of all 256 a/b pairs at WIDTH=4, back-to-back -> every result equals a+b, err_sticky remains 0.
